// File: rtl/mil_rt_rx_msg.sv
// MIL-STD-1553 RT receive-message assembler: validates command words, buffers data words
// and commits whole messages atomically. Optional broadcast support: MIL_RT_BCAST_EN.
module mil_rt_rx_msg #(
   parameter int DEPTH_LOG2 = 6,
   parameter int GAP_TO     = 1200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          rt_addr,
   input  logic                rx_stb,
   input  logic [15:0]         rx_dat,
   input  logic                rx_cw,
   input  logic                rx_ok,
   output logic                msg_done,
   output logic                msg_err,
   output logic [2:0]          err_code,
   output logic [4:0]          cmd_sa,
   output logic [5:0]          cmd_wc,
   output logic                tx_req,
   output logic                mode_stb,
`ifdef MIL_RT_BCAST_EN
   output logic                bcast,
`endif
   input  logic                rd_en,
   output logic [15:0]         rd_dat,
   output logic                rd_empty,
   output logic [DEPTH_LOG2:0] rd_count,
   output logic                dbg_state
);
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int GW    = $clog2(GAP_TO + 1);

   typedef enum logic {S_IDLE = 1'b0, S_RX_DW = 1'b1} state_t;

   state_t        r_state;
   logic [15:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_commit_ptr;
   logic [5:0]    r_cnt;
   logic [GW-1:0] r_gap;
   logic          r_msg_done;
   logic          r_msg_err;
   logic          r_tx_req;
   logic          r_mode_stb;
   logic [2:0]    r_err_code;
   logic [4:0]    r_cmd_sa;
   logic [5:0]    r_cmd_wc;

   logic          w_cmd, w_own, w_bc, w_match, w_mode_cmd, w_tx_cmd, w_start;
   logic          w_in_rx, w_dw, w_full, w_wr, w_commit, w_gap_exp, w_abort, w_pop;
   logic [2:0]    w_code;
   logic [4:0]    w_sa;
   logic [5:0]    w_wc;
   logic [PW-1:0] w_fill;
   logic [PW-1:0] w_rd_count;

   // Command word decode; a WC field of 0 means 32 words.
   assign w_cmd      = rx_stb & rx_cw;
   assign w_sa       = rx_dat[9:5];
   assign w_wc       = {rx_dat[4:0] == 5'd0, rx_dat[4:0]};
   assign w_own      = rx_dat[15:11] == rt_addr;
`ifdef MIL_RT_BCAST_EN
   assign w_bc       = rx_dat[15:11] == 5'd31;
`else
   assign w_bc       = 1'b0;
`endif
   assign w_match    = w_cmd & rx_ok & (w_own | w_bc);
   assign w_mode_cmd = w_match & ((w_sa == 5'd0) | (w_sa == 5'd31));
   assign w_tx_cmd   = w_match & ~w_mode_cmd & rx_dat[10];
   assign w_start    = w_match & ~w_mode_cmd & ~rx_dat[10];

   // Fullness counts uncommitted words, so it is measured from the write pointer.
   assign w_in_rx    = r_state == S_RX_DW;
   assign w_dw       = w_in_rx & rx_stb & ~rx_cw;
   assign w_fill     = r_wr_ptr - r_rd_ptr;
   assign w_full     = w_fill == PW'(DEPTH);
   assign w_wr       = w_dw & rx_ok & ~w_full;
   assign w_commit   = w_wr & ((r_cnt + 6'd1) == r_cmd_wc);
   assign w_gap_exp  = w_in_rx & ~rx_stb & (r_gap == GW'(GAP_TO - 1));
   assign w_abort    = (w_in_rx & w_cmd) | (w_dw & ~w_wr) | w_gap_exp;

   always_comb begin
      w_code = 3'd0;
      if (w_in_rx & w_cmd)
         w_code = 3'd2;
      else if (w_dw & ~rx_ok)
         w_code = 3'd1;
      else if (w_dw & w_full)
         w_code = 3'd4;
      else if (w_gap_exp)
         w_code = 3'd3;
   end

   assign w_rd_count = r_commit_ptr - r_rd_ptr;
   assign w_pop      = rd_en & (w_rd_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_commit_ptr <= '0;
         r_cnt        <= '0;
         r_gap        <= '0;
         r_msg_done   <= 1'b0;
         r_msg_err    <= 1'b0;
         r_tx_req     <= 1'b0;
         r_mode_stb   <= 1'b0;
         r_err_code   <= 3'd0;
         r_cmd_sa     <= 5'd0;
         r_cmd_wc     <= 6'd0;
      end else begin
         r_msg_done <= w_commit;
         r_msg_err  <= w_abort;
         r_tx_req   <= w_tx_cmd & ~w_bc;
         r_mode_stb <= w_mode_cmd;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_abort) begin
            r_err_code <= w_code;
            r_wr_ptr   <= r_commit_ptr;
         end
         case (r_state)
            S_IDLE: ;
            S_RX_DW: begin
               if (w_wr) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  r_cnt    <= r_cnt + 6'd1;
                  r_gap    <= '0;
                  if (w_commit) begin
                     r_commit_ptr <= r_wr_ptr + 1'b1;
                     r_state      <= S_IDLE;
                  end
               end else if (w_abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // A fresh receive command wins over an abort raised by the same word.
         if (w_start) begin
            r_cmd_sa <= w_sa;
            r_cmd_wc <= w_wc;
            r_cnt    <= 6'd0;
            r_gap    <= '0;
            r_state  <= S_RX_DW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= rx_dat;
   end

`ifdef MIL_RT_BCAST_EN
   logic r_msg_bc;
   logic r_bcast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msg_bc <= 1'b0;
         r_bcast  <= 1'b0;
      end else begin
         if (w_start)
            r_msg_bc <= w_bc;
         if (w_commit)
            r_bcast <= r_msg_bc;
      end
   end

   assign bcast = r_bcast;
`endif

   assign msg_done  = r_msg_done;
   assign msg_err   = r_msg_err;
   assign err_code  = r_err_code;
   assign cmd_sa    = r_cmd_sa;
   assign cmd_wc    = r_cmd_wc;
   assign tx_req    = r_tx_req;
   assign mode_stb  = r_mode_stb;
   assign rd_dat    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
   assign rd_count  = w_rd_count;
   assign rd_empty  = w_rd_count == '0;
   assign dbg_state = r_state == S_RX_DW;
endmodule

// File: tb/tb_mil_rt_rx_msg.sv
// Bench for mil_rt_rx_msg: message-level queue model checked every cycle, plus
// directed scenarios with literal expectations and randomized traffic.
module tb_mil_rt_rx_msg;
   localparam int DEPTH_LOG2 = 6;
   localparam int DEPTH      = 64;
   localparam int GAP_TO     = 1200;
`ifdef MIL_RT_BCAST_EN
   localparam bit BC_EN = 1'b1;
`else
   localparam bit BC_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [4:0]          rt_addr = 5'd3;
   logic                rx_stb = 1'b0;
   logic [15:0]         rx_dat = 16'h0;
   logic                rx_cw = 1'b0;
   logic                rx_ok = 1'b0;
   logic                rd_en = 1'b0;
   logic                msg_done, msg_err, tx_req, mode_stb, rd_empty, dbg_state;
   logic [2:0]          err_code;
   logic [4:0]          cmd_sa;
   logic [5:0]          cmd_wc;
   logic [15:0]         rd_dat;
   logic [DEPTH_LOG2:0] rd_count;
`ifdef MIL_RT_BCAST_EN
   logic                bcast;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   mil_rt_rx_msg #(.DEPTH_LOG2(DEPTH_LOG2), .GAP_TO(GAP_TO)) dut (
      .clk(clk), .rst(rst), .rt_addr(rt_addr),
      .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_cw(rx_cw), .rx_ok(rx_ok),
      .msg_done(msg_done), .msg_err(msg_err), .err_code(err_code),
      .cmd_sa(cmd_sa), .cmd_wc(cmd_wc), .tx_req(tx_req), .mode_stb(mode_stb),
`ifdef MIL_RT_BCAST_EN
      .bcast(bcast),
`endif
      .rd_en(rd_en), .rd_dat(rd_dat), .rd_empty(rd_empty), .rd_count(rd_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (message level) ----------------
   logic [15:0] exp_q[$];
   logic [15:0] pend_q[$];
   bit m_busy, m_done, m_err, m_tx, m_mode, m_bc, m_bcast;
   int m_idle, m_code, m_sa, m_wcl, m_total;

   task automatic model_abort(input int code);
      m_err  = 1'b1;
      m_code = code;
      m_busy = 1'b0;
      pend_q.delete();
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_err = 0; m_tx = 0; m_mode = 0; m_bc = 0; m_bcast = 0;
         m_idle = 0; m_code = 0; m_sa = 0; m_wcl = 0;
         exp_q.delete();
         pend_q.delete();
      end else begin
         m_total = exp_q.size() + pend_q.size();
         m_done = 0; m_err = 0; m_tx = 0; m_mode = 0;
         if (rd_en && exp_q.size() != 0)
            void'(exp_q.pop_front());
         if (rx_stb && rx_cw) begin
            if (m_busy)
               model_abort(2);
            if (rx_ok && (rx_dat[15:11] == rt_addr || (BC_EN && rx_dat[15:11] == 5'd31))) begin
               if (rx_dat[9:5] == 5'd0 || rx_dat[9:5] == 5'd31)
                  m_mode = 1;
               else if (rx_dat[10])
                  m_tx = !(BC_EN && rx_dat[15:11] == 5'd31);
               else begin
                  m_busy = 1;
                  m_sa   = int'(rx_dat[9:5]);
                  m_wcl  = (rx_dat[4:0] == 5'd0) ? 32 : int'(rx_dat[4:0]);
                  m_idle = 0;
                  m_bc   = BC_EN && rx_dat[15:11] == 5'd31;
                  pend_q.delete();
               end
            end
         end else if (m_busy) begin
            if (rx_stb) begin
               if (!rx_ok)
                  model_abort(1);
               else if (m_total == DEPTH)
                  model_abort(4);
               else begin
                  pend_q.push_back(rx_dat);
                  m_idle = 0;
                  if (pend_q.size() == m_wcl) begin
                     foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                     pend_q.delete();
                     m_busy  = 0;
                     m_done  = 1;
                     m_bcast = m_bc;
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == GAP_TO)
                  model_abort(3);
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("msg_done", 32'(msg_done), 32'(m_done));
         check("msg_err", 32'(msg_err), 32'(m_err));
         check("err_code", 32'(err_code), m_code);
         check("cmd_sa", 32'(cmd_sa), m_sa);
         check("cmd_wc", 32'(cmd_wc), m_wcl);
         check("tx_req", 32'(tx_req), 32'(m_tx));
         check("mode_stb", 32'(mode_stb), 32'(m_mode));
         check("rd_count", 32'(rd_count), exp_q.size());
         check("rd_empty", 32'(rd_empty), 32'(exp_q.size() == 0));
         check("dbg_state", 32'(dbg_state), 32'(m_busy));
         if (exp_q.size() != 0)
            check("rd_dat", 32'(rd_dat), 32'(exp_q[0]));
`ifdef MIL_RT_BCAST_EN
         check("bcast", 32'(bcast), 32'(m_bcast));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [15:0] dat, input logic cw, input logic ok);
      rx_dat = dat; rx_cw = cw; rx_ok = ok; rx_stb = 1'b1;
      tick();
      rx_stb = 1'b0;
      rx_dat = 16'($urandom);
      rx_cw  = 1'($urandom_range(0, 1));
      rx_ok  = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      rd_en = 1'b1;
      idle(DEPTH + 4);
      rd_en = 1'b0;
   endtask

   task automatic read_expect(input string name, input logic [15:0] val);
      check(name, 32'(rd_dat), 32'(val));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   function automatic logic [15:0] cwd(input logic [4:0] rta, input logic tr,
                                       input logic [4:0] sa, input logic [4:0] wc);
      return {rta, tr, sa, wc};
   endfunction

   task automatic rand_item();
      int k, wc, f;
      logic [4:0] rta;
      k = $urandom_range(0, 99);
      rd_en = ($urandom_range(0, 2) == 0);
      if (k < 55 || (k >= 93 && k < 97)) begin
         wc  = $urandom_range(1, 8);
         rta = (k < 55) ? rt_addr : 5'd31;
         send(cwd(rta, 1'b0, 5'($urandom_range(1, 30)), 5'(wc)), 1'b1, 1'b1);
         for (int i = 0; i < wc; i++) begin
            f = $urandom_range(0, 99);
            rd_en = ($urandom_range(0, 2) == 0);
            if (f < 3) begin
               send(16'($urandom), 1'b0, 1'b0);
               break;
            end else if (f < 6) begin
               break;
            end else if (f == 6) begin
               idle(GAP_TO + $urandom_range(0, 3));
            end
            send(16'($urandom), 1'b0, 1'b1);
            idle($urandom_range(0, 2));
         end
      end else if (k < 65) begin
         send(cwd(rt_addr, 1'b1, 5'($urandom_range(1, 30)), 5'($urandom)), 1'b1, 1'b1);
      end else if (k < 72) begin
         send(cwd(rt_addr, 1'b0, ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31, 5'($urandom)), 1'b1, 1'b1);
      end else if (k < 80) begin
         rta = 5'($urandom_range(0, 31));
         if (rta == rt_addr) rta = rt_addr ^ 5'd1;
         send(cwd(rta, 1'($urandom), 5'($urandom), 5'($urandom)), 1'b1, 1'b1);
      end else if (k < 87) begin
         send(cwd(rt_addr, 1'b0, 5'($urandom_range(1, 30)), 5'($urandom)), 1'b1, 1'b0);
      end else if (k < 93) begin
         send(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      end else begin
         idle($urandom_range(1, 20));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle(3);
      rst = 1'b0;
      tick();
      check("reset_rd_empty", 32'(rd_empty), 32'd1);
      check("reset_rd_count", 32'(rd_count), 32'd0);
      check("reset_err_code", 32'(err_code), 32'd0);
      check("reset_cmd_wc", 32'(cmd_wc), 32'd0);
      chk_en = 1'b1;

      // Plain 4-word receive message
      send(16'h1844, 1'b1, 1'b1);
      check("t1_in_rx", 32'(dbg_state), 32'd1);
      for (int i = 1; i <= 4; i++) send(16'hA000 + 16'(i), 1'b0, 1'b1);
      check("t1_msg_done", 32'(msg_done), 32'd1);
      check("t1_cmd_sa", 32'(cmd_sa), 32'd2);
      check("t1_cmd_wc", 32'(cmd_wc), 32'd4);
      check("t1_rd_count", 32'(rd_count), 32'd4);
      for (int i = 1; i <= 4; i++) read_expect("t1_rd_dat", 16'hA000 + 16'(i));
      check("t1_empty", 32'(rd_empty), 32'd1);

      // Data-word parity error
      send(16'h1844, 1'b1, 1'b1);
      send(16'hA001, 1'b0, 1'b1);
      send(16'hA002, 1'b0, 1'b1);
      send(16'hA003, 1'b0, 1'b0);
      check("t2_msg_err", 32'(msg_err), 32'd1);
      check("t2_err_code", 32'(err_code), 32'd1);
      check("t2_rd_count", 32'(rd_count), 32'd0);

      // Gap timeout, then a clean 2-word message
      send(16'h1844, 1'b1, 1'b1);
      send(16'hA001, 1'b0, 1'b1);
      send(16'hA002, 1'b0, 1'b1);
      idle(GAP_TO - 1);
      check("t3_no_err_yet", 32'(msg_err), 32'd0);
      tick();
      check("t3_msg_err", 32'(msg_err), 32'd1);
      check("t3_err_code", 32'(err_code), 32'd3);
      idle(100);
      send(16'h1842, 1'b1, 1'b1);
      send(16'hB001, 1'b0, 1'b1);
      send(16'hB002, 1'b0, 1'b1);
      check("t3_msg_done", 32'(msg_done), 32'd1);
      check("t3_rd_count", 32'(rd_count), 32'd2);
      read_expect("t3_rd_dat", 16'hB001);
      read_expect("t3_rd_dat", 16'hB002);

      // Transmit, foreign RT, mode command
      send(16'h1C20, 1'b1, 1'b1);
      check("t4_tx_req", 32'(tx_req), 32'd1);
      check("t4_tx_idle", 32'(dbg_state), 32'd0);
      send(16'h2844, 1'b1, 1'b1);
      check("t4_rt5_tx", 32'(tx_req), 32'd0);
      check("t4_rt5_state", 32'(dbg_state), 32'd0);
      send(16'h1800, 1'b1, 1'b1);
      check("t4_mode_stb", 32'(mode_stb), 32'd1);

      // Command word interrupts a message and starts a new one
      send(16'h1844, 1'b1, 1'b1);
      send(16'hD001, 1'b0, 1'b1);
      send(16'h1842, 1'b1, 1'b1);
      check("ab2_msg_err", 32'(msg_err), 32'd1);
      check("ab2_err_code", 32'(err_code), 32'd2);
      check("ab2_restart", 32'(dbg_state), 32'd1);
      send(16'hD002, 1'b0, 1'b1);
      send(16'hD003, 1'b0, 1'b1);
      check("ab2_rd_count", 32'(rd_count), 32'd2);
      read_expect("ab2_rd_dat", 16'hD002);
      read_expect("ab2_rd_dat", 16'hD003);

      // Broadcast receive
      send(16'hF841, 1'b1, 1'b1);
      send(16'hC001, 1'b0, 1'b1);
`ifdef MIL_RT_BCAST_EN
      check("t6_msg_done", 32'(msg_done), 32'd1);
      check("t6_bcast", 32'(bcast), 32'd1);
      check("t6_rd_count", 32'(rd_count), 32'd1);
`else
      check("t6_no_done", 32'(msg_done), 32'd0);
      check("t6_rd_count", 32'(rd_count), 32'd0);
`endif
      drain();

      // Buffer full, then read and commit in the same cycle
      for (int m = 0; m < 2; m++) begin
         send(16'h1840, 1'b1, 1'b1);
         for (int i = 0; i < 32; i++) send(16'h5000 + 16'(m * 32 + i), 1'b0, 1'b1);
      end
      check("t5_full_count", 32'(rd_count), 32'd64);
      send(16'h1841, 1'b1, 1'b1);
      send(16'h5EEE, 1'b0, 1'b1);
      check("t5_msg_err", 32'(msg_err), 32'd1);
      check("t5_err_code", 32'(err_code), 32'd4);
      check("t5_count_kept", 32'(rd_count), 32'd64);
      rd_en = 1'b1;
      idle(2);
      rd_en = 1'b0;
      send(16'h1842, 1'b1, 1'b1);
      send(16'h5F01, 1'b0, 1'b1);
      rd_en = 1'b1;
      send(16'h5F02, 1'b0, 1'b1);
      rd_en = 1'b0;
      check("t5_rd_commit_done", 32'(msg_done), 32'd1);
      check("t5_rd_commit_count", 32'(rd_count), 32'd63);
      drain();

      // Reset mid-message drops committed and pending words
      send(16'h1842, 1'b1, 1'b1);
      send(16'hE001, 1'b0, 1'b1);
      send(16'hE002, 1'b0, 1'b1);
      send(16'h1844, 1'b1, 1'b1);
      send(16'hE003, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_rd_empty", 32'(rd_empty), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_cmd_sa", 32'(cmd_sa), 32'd0);

      // Randomized traffic against the model
      rt_addr = 5'($urandom_range(0, 30));
      repeat (300) rand_item();
      idle(GAP_TO + 2);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
